main_mem_ctrl: RTL and testbench

MAIN_MEM_CTRL -- requirements
Module: main_mem_ctrl

---
 rtl/main_mem_pkg.sv | 23 ++
 rtl/main_mem_ctrl_mem_array.sv | 32 +++
 rtl/main_mem_ctrl.sv | 150 +++++++++++++++
 tb/tb_main_mem_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/main_mem_pkg.sv
// Shared types and constants for the main memory controller.
package main_mem_pkg;

  localparam int unsigned BLOCK_BYTES = 4;
  localparam int unsigned BEAT_W      = 2;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RD_BURST,
    WR_BURST
  } mem_state_e;

  // Byte offset inside a block; 2-bit arithmetic keeps it from carrying into addr bit 2.
  function automatic logic [BEAT_W-1:0] wrap_beat(input logic [BEAT_W-1:0] start,
                                                  input logic [BEAT_W-1:0] beat);
    return start + beat;
  endfunction

endpackage

// File: rtl/main_mem_ctrl_mem_array.sv
// Single-port synchronous byte RAM: one access per cycle, 1-cycle registered read.
// Contents are not reset.
module mem_array
  import main_mem_pkg::*;
#(
  parameter int unsigned AW = 10
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**AW];
  logic [DATA_W-1:0] rdata_q;

  // Byte write, or registered read of the addressed byte.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/main_mem_ctrl.sv
// Main memory controller: services 4-byte block refills and writebacks from the
// cache over a bidirectional byte bus after a programmable wait.
// Optional feature: define MAIN_MEM_CRITICAL_WORD_FIRST_EN to start read bursts
// at the requested byte offset and wrap within the block.
module main_mem_ctrl
  import main_mem_pkg::*;
#(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned MEM_AW  = 10
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] addr_mem,
  input  logic        rd_mem,
  input  logic        wr_mem,
  inout  logic [7:0]  data_mem,
  output logic        ready_mem
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_BYTES - 1);

  mem_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                arm_q, arm_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [BEAT_W-1:0]   start_q, start_d;
  logic [MEM_AW-3:0]   base_q, base_d;
  logic                wr_q, wr_d;

  logic                ram_en;
  logic                ram_we;
  logic [BEAT_W-1:0]   ram_off;
  logic [DATA_W-1:0]   ram_rdata;
  logic                unused_addr;

  assign unused_addr = ^{addr_mem[15:MEM_AW], addr_mem[1:0]};

  // State and request registers; reset abandons any burst in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      arm_q   <= 1'b0;
      beat_q  <= '0;
      start_q <= '0;
      base_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      arm_q   <= arm_d;
      beat_q  <= beat_d;
      start_q <= start_d;
      base_q  <= base_d;
      wr_q    <= wr_d;
    end
  end

  // Next-state, wait countdown, beat sequencing and array access control.
  // WAIT counts LATENCY-1..0, then spends one armed cycle issuing the beat-0
  // array read, giving LATENCY+1 cycles from capture to the first beat.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    arm_d   = arm_q;
    beat_d  = beat_q;
    start_d = start_q;
    base_d  = base_q;
    wr_d    = wr_q;
    ram_en  = 1'b0;
    ram_we  = 1'b0;
    ram_off = beat_q;

    unique case (state_q)
      IDLE: begin
        if (wr_mem || rd_mem) begin
          base_d  = addr_mem[MEM_AW-1:2];
          wr_d    = wr_mem;
          start_d = '0;
`ifdef MAIN_MEM_CRITICAL_WORD_FIRST_EN
          if (!wr_mem) begin
            start_d = addr_mem[1:0];
          end
`endif
          cnt_d   = CNT_W'(LATENCY - 1);
          arm_d   = 1'b0;
          beat_d  = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!arm_q) begin
          arm_d = 1'b1;
        end else begin
          arm_d   = 1'b0;
          beat_d  = '0;
          state_d = wr_q ? WR_BURST : RD_BURST;
        end
        if (arm_q && !wr_q) begin
          ram_en  = 1'b1;
          ram_off = start_q;
        end
      end
      RD_BURST: begin
        if (beat_q != LAST_BEAT) begin
          ram_en  = 1'b1;
          ram_off = wrap_beat(start_q, beat_q + BEAT_W'(1));
          beat_d  = beat_q + BEAT_W'(1);
        end else begin
          beat_d  = '0;
          state_d = IDLE;
        end
      end
      WR_BURST: begin
        if (wr_mem) begin
          ram_en  = 1'b1;
          ram_we  = 1'b1;
          ram_off = beat_q;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else begin
          beat_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  mem_array #(
    .AW (MEM_AW)
  ) u_mem (
    .clk_i   (clock),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  ({base_q, ram_off}),
    .wdata_i (data_mem),
    .rdata_o (ram_rdata)
  );

  assign data_mem  = (state_q == RD_BURST) ? ram_rdata : 'z;
  assign ready_mem = (state_q != WAIT);

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Directed bench for main_mem_ctrl (LATENCY=4, MEM_AW=10). The bench drives 0x00
// onto data_mem whenever the controller should not be driving, so a released
// bus reads back 0x00.
module tb_main_mem_ctrl;
  import main_mem_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] addr_mem = '0;
  logic        rd_mem = 1'b0;
  logic        wr_mem = 1'b0;
  logic [7:0]  tb_drv = '0;
  logic        tb_drv_en = 1'b1;
  wire  [7:0]  data_mem;
  logic        ready_mem;

  int errors = 0;
  int checks = 0;

`ifdef MAIN_MEM_CRITICAL_WORD_FIRST_EN
  localparam logic [31:0] EXP_08B = 32'h33221144;
  localparam logic [31:0] EXP_09B = 32'hCCBBAADD;
`else
  localparam logic [31:0] EXP_08B = 32'h44332211;
  localparam logic [31:0] EXP_09B = 32'hDDCCBBAA;
`endif

  assign data_mem = tb_drv_en ? tb_drv : 'z;

  main_mem_ctrl #(
    .LATENCY (4),
    .MEM_AW  (10)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .addr_mem  (addr_mem),
    .rd_mem    (rd_mem),
    .wr_mem    (wr_mem),
    .data_mem  (data_mem),
    .ready_mem (ready_mem)
  );

  initial forever #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1);
  end

  // Read burst: returns beats (beat 0 in [7:0]), wait cycles seen low,
  // ready per beat, and bus/ready one cycle after the burst.
  // launch=0 means rd_mem is already held and the next edge captures it.
  task automatic rd_burst(input logic [15:0] a, input logic launch,
                          output logic [31:0] got, output int low_cnt,
                          output logic [3:0] beat_rdy, output logic [7:0] rel_bus,
                          output logic rel_rdy);
    if (launch) begin
      @(posedge clock); #1;
      addr_mem = a;
      rd_mem   = 1'b1;
    end
    tb_drv_en = 1'b0;
    low_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      rd_mem = 1'b0;
      @(negedge clock);
      if (ready_mem === 1'b0) low_cnt++;
    end
    for (int b = 0; b < 4; b++) begin
      @(posedge clock); #1;
      @(negedge clock);
      got[8*b +: 8] = data_mem;
      beat_rdy[b]   = ready_mem;
    end
    @(posedge clock); #1;
    tb_drv    = 8'h00;
    tb_drv_en = 1'b1;
    @(negedge clock);
    rel_bus = data_mem;
    rel_rdy = ready_mem;
  endtask

  // Write burst of nbeats beats (4 = full); wr_mem drops during beat nbeats otherwise.
  task automatic wr_burst(input logic [15:0] a, input logic [31:0] data, input int nbeats,
                          input logic with_rd, output int low_cnt, output logic [3:0] beat_rdy);
    @(posedge clock); #1;
    addr_mem  = a;
    wr_mem    = 1'b1;
    rd_mem    = with_rd;
    tb_drv_en = 1'b1;
    tb_drv    = 8'h00;
    low_cnt   = 0;
    beat_rdy  = '0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      @(negedge clock);
      if (ready_mem === 1'b0) low_cnt++;
    end
    for (int b = 0; b < 4; b++) begin
      @(posedge clock); #1;
      if (b == nbeats) begin
        wr_mem = 1'b0;
        break;
      end
      tb_drv = data[8*b +: 8];
      @(negedge clock);
      beat_rdy[b] = ready_mem;
    end
    @(posedge clock); #1;
    wr_mem = 1'b0;
    tb_drv = 8'h00;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    checks++; if (ready_mem !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, expected 1", ready_mem); end
    checks++; if (data_mem !== 8'h00) begin errors++; $display("FAIL reset_bus_released: got %h, expected 00", data_mem); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state: got %0d, expected IDLE", dut.state_q); end
    checks++; if (dut.cnt_q !== 4'd0) begin errors++; $display("FAIL reset_counter: got %0d, expected 0", dut.cnt_q); end
    checks++; if (dut.beat_q !== 2'd0) begin errors++; $display("FAIL reset_beat: got %0d, expected 0", dut.beat_q); end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (ready_mem !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b, expected 1", ready_mem); end
    checks++; if (data_mem !== 8'h00) begin errors++; $display("FAIL post_reset_bus: got %h, expected 00", data_mem); end
    checks++; if (dut.ram_en !== 1'b0) begin errors++; $display("FAIL post_reset_no_access: got %b, expected 0", dut.ram_en); end
  endtask

  task automatic test_preload_read();
    logic [31:0] got; int low; logic [3:0] br; logic [7:0] rb; logic rr;
    wr_burst(16'h0088, 32'h44332211, 4, 1'b0, low, br);
    checks++; if (low !== 5) begin errors++; $display("FAIL preload_wait: got %0d low cycles, expected 5", low); end
    checks++; if (br !== 4'hF) begin errors++; $display("FAIL preload_beat_ready: got %b, expected 1111", br); end
    rd_burst(16'hC08B, 1'b1, got, low, br, rb, rr);
    checks++; if (low !== 5) begin errors++; $display("FAIL read_wait: got %0d low cycles, expected 5", low); end
    checks++; if (got !== EXP_08B) begin errors++; $display("FAIL read_08B_data: got %h, expected %h", got, EXP_08B); end
    checks++; if (br !== 4'hF) begin errors++; $display("FAIL read_beat_ready: got %b, expected 1111", br); end
    checks++; if (rb !== 8'h00) begin errors++; $display("FAIL read_release: got %h, expected 00", rb); end
    checks++; if (rr !== 1'b1) begin errors++; $display("FAIL read_idle_ready: got %b, expected 1", rr); end
  endtask

  task automatic test_write_read();
    logic [31:0] got; int low; logic [3:0] br; logic [7:0] rb; logic rr;
    wr_burst(16'hC09B, 32'hDDCCBBAA, 4, 1'b0, low, br);
    checks++; if (low !== 5) begin errors++; $display("FAIL wr09B_wait: got %0d low cycles, expected 5", low); end
    rd_burst(16'hC09B, 1'b1, got, low, br, rb, rr);
    checks++; if (got !== EXP_09B) begin errors++; $display("FAIL rd09B_data: got %h, expected %h", got, EXP_09B); end
    checks++; if (rb !== 8'h00) begin errors++; $display("FAIL rd09B_release: got %h, expected 00", rb); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] got; int low; logic [3:0] br; logic [7:0] rb; logic rr;
    wr_burst(16'h0090, 32'h8D7C6B5A, 4, 1'b1, low, br);
    checks++; if (br !== 4'hF) begin errors++; $display("FAIL simul_write_first: got beat ready %b, expected 1111", br); end
    rd_burst(16'h0090, 1'b0, got, low, br, rb, rr);
    checks++; if (low !== 5) begin errors++; $display("FAIL simul_read_wait: got %0d low cycles, expected 5", low); end
    checks++; if (got !== 32'h8D7C6B5A) begin errors++; $display("FAIL simul_read_data: got %h, expected 8d7c6b5a", got); end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] got; int low; logic [3:0] br; logic [7:0] rb; logic rr;
    @(posedge clock); #1;
    addr_mem  = 16'h0088;
    rd_mem    = 1'b1;
    tb_drv_en = 1'b0;
    repeat (5) begin @(posedge clock); #1; rd_mem = 1'b0; end
    repeat (3) begin @(posedge clock); #1; end
    @(negedge clock);
    checks++; if (data_mem !== 8'h33) begin errors++; $display("FAIL midrd_beat2: got %h, expected 33", data_mem); end
    #1;
    reset_n   = 1'b0;
    tb_drv    = 8'h00;
    tb_drv_en = 1'b1;
    #1;
    checks++; if (ready_mem !== 1'b1) begin errors++; $display("FAIL midrd_async_ready: got %b, expected 1", ready_mem); end
    checks++; if (data_mem !== 8'h00) begin errors++; $display("FAIL midrd_async_release: got %h, expected 00", data_mem); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    rd_burst(16'h0088, 1'b1, got, low, br, rb, rr);
    checks++; if (got !== 32'h44332211) begin errors++; $display("FAIL midrd_contents: got %h, expected 44332211", got); end
  endtask

  task automatic test_write_abort();
    logic [31:0] got; int low; logic [3:0] br; logic [7:0] rb; logic rr;
    wr_burst(16'h00A0, 32'h04030201, 4, 1'b0, low, br);
    wr_burst(16'h00A0, 32'hF4F3F2F1, 2, 1'b0, low, br);
    checks++; if (br !== 4'b0011) begin errors++; $display("FAIL abort_beat_ready: got %b, expected 0011", br); end
    rd_burst(16'h00A0, 1'b1, got, low, br, rb, rr);
    checks++; if (got !== 32'h0403F2F1) begin errors++; $display("FAIL abort_contents: got %h, expected 0403f2f1", got); end
    checks++; if (low !== 5) begin errors++; $display("FAIL abort_then_read_wait: got %0d low cycles, expected 5", low); end
  endtask

  initial begin
    test_reset();
    test_preload_read();
    test_write_read();
    test_simultaneous();
    test_reset_mid_read();
    test_write_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
